// File: rtl/ysyx_23060124_mem_arbiter_pkg.sv
// Shared types and constants for the IFU/LSU memory arbiter.
// Optional feature: YSYX_23060124_ARB_RR_EN selects round-robin arbitration.
package ysyx_23060124_mem_arbiter_pkg;

  localparam int unsigned ysyx_23060124_ISA_WIDTH = 32;
  localparam int unsigned STRB_WIDTH              = 4;

  // Bit positions inside the one-hot grant vector
  localparam int unsigned GNT_LSU = 0;
  localparam int unsigned GNT_IFU = 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_RESP = 2'd2
  } arb_state_e;

  typedef enum logic {
    OWN_LSU = 1'b0,
    OWN_IFU = 1'b1
  } arb_owner_e;

  typedef struct packed {
    logic [ysyx_23060124_ISA_WIDTH-1:0] addr;
    logic [ysyx_23060124_ISA_WIDTH-1:0] wdata;
    logic                               wen;
    logic [STRB_WIDTH-1:0]              wstrb;
  } mem_req_t;

  function automatic arb_owner_e grant_owner(input logic [1:0] grant);
    return grant[GNT_IFU] ? OWN_IFU : OWN_LSU;
  endfunction

endpackage

// File: rtl/ysyx_23060124_mem_arbiter_if.sv
// IFU, LSU and shared-memory handshake bundle; master is the arbiter's view.
interface ysyx_23060124_mem_arbiter_if;
  import ysyx_23060124_mem_arbiter_pkg::*;

  logic                               ifu_req_valid;
  logic                               ifu_req_ready;
  logic [ysyx_23060124_ISA_WIDTH-1:0] ifu_addr;
  logic                               ifu_resp_valid;
  logic [ysyx_23060124_ISA_WIDTH-1:0] ifu_rdata;

  logic                               lsu_req_valid;
  logic                               lsu_req_ready;
  logic [ysyx_23060124_ISA_WIDTH-1:0] lsu_addr;
  logic                               lsu_wen;
  logic [ysyx_23060124_ISA_WIDTH-1:0] lsu_wdata;
  logic [STRB_WIDTH-1:0]              lsu_wstrb;
  logic                               lsu_resp_valid;
  logic [ysyx_23060124_ISA_WIDTH-1:0] lsu_rdata;

  logic                               mem_req_valid;
  logic                               mem_req_ready;
  logic [ysyx_23060124_ISA_WIDTH-1:0] mem_addr;
  logic [ysyx_23060124_ISA_WIDTH-1:0] mem_wdata;
  logic                               mem_wen;
  logic [STRB_WIDTH-1:0]              mem_wstrb;
  logic                               mem_resp_valid;
  logic [ysyx_23060124_ISA_WIDTH-1:0] mem_rdata;

  modport master (
    input  ifu_req_valid, ifu_addr,
    input  lsu_req_valid, lsu_addr, lsu_wen, lsu_wdata, lsu_wstrb,
    input  mem_req_ready, mem_resp_valid, mem_rdata,
    output ifu_req_ready, ifu_resp_valid, ifu_rdata,
    output lsu_req_ready, lsu_resp_valid, lsu_rdata,
    output mem_req_valid, mem_addr, mem_wdata, mem_wen, mem_wstrb
  );

  modport slave (
    output ifu_req_valid, ifu_addr,
    output lsu_req_valid, lsu_addr, lsu_wen, lsu_wdata, lsu_wstrb,
    output mem_req_ready, mem_resp_valid, mem_rdata,
    input  ifu_req_ready, ifu_resp_valid, ifu_rdata,
    input  lsu_req_ready, lsu_resp_valid, lsu_rdata,
    input  mem_req_valid, mem_addr, mem_wdata, mem_wen, mem_wstrb
  );

endinterface

// File: rtl/ysyx_23060124_mem_arbiter_pick.sv
// Winner selection between IFU and LSU; one-hot grant, zero when nobody is valid.
// YSYX_23060124_ARB_RR_EN: ties go to the requester not granted last.
module ysyx_23060124_arb_pick
  import ysyx_23060124_mem_arbiter_pkg::*;
(
  input  logic       ifu_valid_i,
  input  logic       lsu_valid_i,
  input  arb_owner_e last_grant_i,
  output logic [1:0] grant_o
);

`ifdef YSYX_23060124_ARB_RR_EN
  always_comb begin
    grant_o = 2'b00;
    if (ifu_valid_i && lsu_valid_i) begin
      grant_o[GNT_IFU] = (last_grant_i == OWN_LSU);
      grant_o[GNT_LSU] = (last_grant_i == OWN_IFU);
    end else begin
      grant_o[GNT_IFU] = ifu_valid_i;
      grant_o[GNT_LSU] = lsu_valid_i;
    end
  end
`else
  // Fixed priority: the last-grant input carries no information here
  logic unused_last_grant;
  assign unused_last_grant = last_grant_i;

  always_comb begin
    grant_o          = 2'b00;
    grant_o[GNT_LSU] = lsu_valid_i;
    grant_o[GNT_IFU] = ifu_valid_i && !lsu_valid_i;
  end
`endif

endmodule

// File: rtl/ysyx_23060124_mem_arbiter.sv
// Two-client (IFU/LSU) arbiter onto one memory port, one outstanding transaction.
// YSYX_23060124_ARB_RR_EN: round-robin on ties instead of LSU fixed priority.
module ysyx_23060124_mem_arbiter
  import ysyx_23060124_mem_arbiter_pkg::*;
(
  input  logic                          clk,
  input  logic                          i_rst_n,
  ysyx_23060124_mem_arbiter_if.master   bus
);

  arb_state_e state_q, state_d;
  arb_owner_e owner_q, owner_d;
  mem_req_t   pay_q, pay_d;
  mem_req_t   win_pay;
  arb_owner_e win_owner;
  arb_owner_e last_grant;
  arb_owner_e accept_owner;
  logic       accept;
  logic [1:0] grant;

`ifdef YSYX_23060124_ARB_RR_EN
  arb_owner_e last_q, last_d;
  assign last_grant = last_q;
`else
  assign last_grant = OWN_LSU;
`endif

  ysyx_23060124_arb_pick u_pick (
    .ifu_valid_i  (bus.ifu_req_valid),
    .lsu_valid_i  (bus.lsu_req_valid),
    .last_grant_i (last_grant),
    .grant_o      (grant)
  );

  assign win_owner = grant_owner(grant);

  // Fetches never write, so their write fields are forced to zero
  always_comb begin
    win_pay = '0;
    if (win_owner == OWN_IFU) begin
      win_pay.addr = bus.ifu_addr;
    end else begin
      win_pay.addr  = bus.lsu_addr;
      win_pay.wdata = bus.lsu_wdata;
      win_pay.wen   = bus.lsu_wen;
      win_pay.wstrb = bus.lsu_wstrb;
    end
  end

  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    pay_d        = pay_q;
`ifdef YSYX_23060124_ARB_RR_EN
    last_d       = last_q;
`endif
    accept       = 1'b0;
    accept_owner = owner_q;

    bus.mem_req_valid  = 1'b0;
    bus.mem_addr       = '0;
    bus.mem_wdata      = '0;
    bus.mem_wen        = 1'b0;
    bus.mem_wstrb      = '0;
    bus.ifu_req_ready  = 1'b0;
    bus.lsu_req_ready  = 1'b0;
    bus.ifu_resp_valid = 1'b0;
    bus.lsu_resp_valid = 1'b0;
    bus.ifu_rdata      = '0;
    bus.lsu_rdata      = '0;

    unique case (state_q)
      ST_IDLE: begin
        if (|grant) begin
          bus.mem_req_valid = 1'b1;
          {bus.mem_addr, bus.mem_wdata, bus.mem_wen, bus.mem_wstrb} = win_pay;
          owner_d = win_owner;
          pay_d   = win_pay;
          if (bus.mem_req_ready) begin
            accept       = 1'b1;
            accept_owner = win_owner;
            state_d      = ST_RESP;
          end else begin
            state_d = ST_REQ;
          end
        end
      end
      ST_REQ: begin
        bus.mem_req_valid = 1'b1;
        {bus.mem_addr, bus.mem_wdata, bus.mem_wen, bus.mem_wstrb} = pay_q;
        if (bus.mem_req_ready) begin
          accept  = 1'b1;
          state_d = ST_RESP;
        end
      end
      ST_RESP: begin
        if (bus.mem_resp_valid) begin
          state_d = ST_IDLE;
          if (owner_q == OWN_IFU) begin
            bus.ifu_resp_valid = 1'b1;
            bus.ifu_rdata      = bus.mem_rdata;
          end else begin
            // A store ack carries no load data
            bus.lsu_resp_valid = 1'b1;
            bus.lsu_rdata      = pay_q.wen ? '0 : bus.mem_rdata;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (accept) begin
      bus.ifu_req_ready = (accept_owner == OWN_IFU);
      bus.lsu_req_ready = (accept_owner == OWN_LSU);
`ifdef YSYX_23060124_ARB_RR_EN
      last_d = accept_owner;
`endif
    end

    // Outputs stay quiet for the whole reset window
    if (!i_rst_n) begin
      bus.mem_req_valid  = 1'b0;
      bus.mem_addr       = '0;
      bus.mem_wdata      = '0;
      bus.mem_wen        = 1'b0;
      bus.mem_wstrb      = '0;
      bus.ifu_req_ready  = 1'b0;
      bus.lsu_req_ready  = 1'b0;
      bus.ifu_resp_valid = 1'b0;
      bus.lsu_resp_valid = 1'b0;
      bus.ifu_rdata      = '0;
      bus.lsu_rdata      = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!i_rst_n) begin
      state_q <= ST_IDLE;
      owner_q <= OWN_LSU;
      pay_q   <= '0;
`ifdef YSYX_23060124_ARB_RR_EN
      last_q  <= OWN_LSU;
`endif
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      pay_q   <= pay_d;
`ifdef YSYX_23060124_ARB_RR_EN
      last_q  <= last_d;
`endif
    end
  end

endmodule

// File: tb/tb_ysyx_23060124_mem_arbiter.sv
// Directed and randomized bench for the memory arbiter against a transaction-level model.
module tb_ysyx_23060124_mem_arbiter;
  import ysyx_23060124_mem_arbiter_pkg::*;

  logic clk = 1'b0;
  logic i_rst_n = 1'b0;
  always #5 clk = ~clk;

  ysyx_23060124_mem_arbiter_if bus ();

  ysyx_23060124_mem_arbiter dut (
    .clk     (clk),
    .i_rst_n (i_rst_n),
    .bus     (bus)
  );

  int checks = 0;
  int errors = 0;

  // Model: the single open transaction, whether memory took it, and who was served last
  bit          m_open = 1'b0;
  bit          m_acc = 1'b0;
  bit          m_own_ifu = 1'b0;
  bit          m_last_ifu = 1'b0;
  logic [31:0] m_addr = '0;
  logic [31:0] m_wdata = '0;
  logic        m_wen = 1'b0;
  logic [3:0]  m_wstrb = '0;

  // Output values sampled in the most recent cycle
  logic        s_irr, s_irv, s_lrr, s_lrv, s_mrv, s_mwen;
  logic [31:0] s_ird, s_lrd, s_maddr;
  logic [3:0]  s_mwstrb;

  task automatic chk(input string tag, input logic [137:0] obs, input logic [137:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic set_in(input bit iv, input logic [31:0] ia, input bit lv, input logic [31:0] la,
                        input bit lw, input logic [31:0] lwd, input logic [3:0] ls,
                        input bit rdy, input bit rv, input logic [31:0] rd);
    bus.ifu_req_valid  = iv;
    bus.ifu_addr       = ia;
    bus.lsu_req_valid  = lv;
    bus.lsu_addr       = la;
    bus.lsu_wen        = lw;
    bus.lsu_wdata      = lwd;
    bus.lsu_wstrb      = ls;
    bus.mem_req_ready  = rdy;
    bus.mem_resp_valid = rv;
    bus.mem_rdata      = rd;
  endtask

  // One clock: predict outputs from the model, compare at the falling edge, advance the model
  task automatic tick(input string tag);
    bit          e_irr, e_irv, e_lrr, e_lrv, e_mrv, e_mwen, pick_ifu;
    logic [31:0] e_ird, e_lrd, e_ma, e_mwd;
    logic [3:0]  e_ms;
    bit          n_open, n_acc, n_own_ifu, n_last_ifu, n_wen;
    logic [31:0] n_addr, n_wdata;
    logic [3:0]  n_wstrb;
    @(negedge clk);
    {e_irr, e_irv, e_lrr, e_lrv, e_mrv, e_mwen} = '0;
    {e_ird, e_lrd, e_ma, e_mwd, e_ms} = '0;
    n_open = m_open; n_acc = m_acc; n_own_ifu = m_own_ifu; n_last_ifu = m_last_ifu;
    n_addr = m_addr; n_wdata = m_wdata; n_wen = m_wen; n_wstrb = m_wstrb;
    if (!i_rst_n) begin
      n_open = 1'b0; n_acc = 1'b0; n_own_ifu = 1'b0; n_last_ifu = 1'b0;
      n_addr = '0; n_wdata = '0; n_wen = 1'b0; n_wstrb = '0;
    end else if (!m_open) begin
      if (bus.ifu_req_valid || bus.lsu_req_valid) begin
`ifdef YSYX_23060124_ARB_RR_EN
        pick_ifu = bus.ifu_req_valid && (!bus.lsu_req_valid || !m_last_ifu);
`else
        pick_ifu = bus.ifu_req_valid && !bus.lsu_req_valid;
`endif
        n_open = 1'b1;
        n_own_ifu = pick_ifu;
        n_addr  = pick_ifu ? bus.ifu_addr : bus.lsu_addr;
        n_wdata = pick_ifu ? 32'h0 : bus.lsu_wdata;
        n_wen   = pick_ifu ? 1'b0 : bus.lsu_wen;
        n_wstrb = pick_ifu ? 4'h0 : bus.lsu_wstrb;
        e_mrv = 1'b1; e_ma = n_addr; e_mwd = n_wdata; e_mwen = n_wen; e_ms = n_wstrb;
        n_acc = bus.mem_req_ready;
        if (bus.mem_req_ready) begin
          e_irr = pick_ifu; e_lrr = !pick_ifu; n_last_ifu = pick_ifu;
        end
      end
    end else if (!m_acc) begin
      e_mrv = 1'b1; e_ma = m_addr; e_mwd = m_wdata; e_mwen = m_wen; e_ms = m_wstrb;
      if (bus.mem_req_ready) begin
        e_irr = m_own_ifu; e_lrr = !m_own_ifu; n_acc = 1'b1; n_last_ifu = m_own_ifu;
      end
    end else if (bus.mem_resp_valid) begin
      n_open = 1'b0;
      if (m_own_ifu) begin
        e_irv = 1'b1; e_ird = bus.mem_rdata;
      end else begin
        e_lrv = 1'b1; e_lrd = m_wen ? 32'h0 : bus.mem_rdata;
      end
    end
    s_irr = bus.ifu_req_ready; s_irv = bus.ifu_resp_valid; s_ird = bus.ifu_rdata;
    s_lrr = bus.lsu_req_ready; s_lrv = bus.lsu_resp_valid; s_lrd = bus.lsu_rdata;
    s_mrv = bus.mem_req_valid; s_maddr = bus.mem_addr; s_mwen = bus.mem_wen; s_mwstrb = bus.mem_wstrb;
    chk(tag,
        {s_irr, s_irv, s_ird, s_lrr, s_lrv, s_lrd, s_mrv, s_maddr, bus.mem_wdata, s_mwen, s_mwstrb},
        {e_irr, e_irv, e_ird, e_lrr, e_lrv, e_lrd, e_mrv, e_ma, e_mwd, e_mwen, e_ms});
    @(posedge clk);
    m_open = n_open; m_acc = n_acc; m_own_ifu = n_own_ifu; m_last_ifu = n_last_ifu;
    m_addr = n_addr; m_wdata = n_wdata; m_wen = n_wen; m_wstrb = n_wstrb;
    #1;
  endtask

  task automatic do_reset();
    i_rst_n = 1'b0;
    set_in(1, 32'h1111_1111, 1, 32'h2222_2222, 1, 32'h3333_3333, 4'hF, 1, 1, 32'h4444_4444);
    tick("reset_a");
    tick("reset_b");
    i_rst_n = 1'b1;
  endtask

  initial begin
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    do_reset();
    chk("reset_mem_valid", 138'(s_mrv), 138'(0));
    chk("reset_ifu_ready", 138'(s_irr), 138'(0));

    // Single fetch with a two-cycle memory latency
    set_in(1, 32'h8000_0000, 0, 0, 0, 0, 0, 1, 0, 0);
    tick("fetch_c0");
    chk("fetch_accept", 138'(s_irr), 138'(1));
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    tick("fetch_c1");
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h0010_0073);
    tick("fetch_c2");
    chk("fetch_resp_valid", 138'(s_irv), 138'(1));
    chk("fetch_rdata", 138'(s_ird), 138'(32'h0010_0073));
    chk("fetch_lsu_quiet", 138'({s_lrr, s_lrv, s_lrd}), 138'(0));

    // Simultaneous requests straight after reset
    do_reset();
    set_in(1, 32'h8000_0100, 1, 32'h8000_2000, 0, 0, 0, 1, 0, 0);
    tick("tie_c0");
`ifdef YSYX_23060124_ARB_RR_EN
    chk("tie_first_ifu", 138'({s_irr, s_lrr}), 138'(2'b10));
    set_in(0, 0, 1, 32'h8000_2000, 0, 0, 0, 0, 0, 0);
    tick("tie_c1");
    set_in(0, 0, 1, 32'h8000_2000, 0, 0, 0, 0, 1, 32'hAAAA_0001);
    tick("tie_c2");
    set_in(0, 0, 1, 32'h8000_2000, 0, 0, 0, 1, 0, 0);
    tick("tie_c3");
    chk("tie_second_lsu", 138'({s_irr, s_lrr}), 138'(2'b01));
`else
    chk("tie_first_lsu", 138'({s_irr, s_lrr}), 138'(2'b01));
    set_in(1, 32'h8000_0100, 0, 0, 0, 0, 0, 0, 0, 0);
    tick("tie_c1");
    set_in(1, 32'h8000_0100, 0, 0, 0, 0, 0, 0, 1, 32'hAAAA_0001);
    tick("tie_c2");
    set_in(1, 32'h8000_0100, 0, 0, 0, 0, 0, 1, 0, 0);
    tick("tie_c3");
    chk("tie_second_ifu", 138'({s_irr, s_lrr}), 138'(2'b10));
`endif
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 1, 32'hAAAA_0002);
    tick("tie_c4");

    // Stalled fetch keeps its payload while the LSU turns up
    set_in(1, 32'h8000_0200, 0, 0, 0, 0, 0, 0, 0, 0);
    tick("stall_c0");
    set_in(1, 32'h8000_0200, 1, 32'h8000_3000, 0, 0, 0, 0, 0, 0);
    tick("stall_c1");
    chk("stall_addr_c1", 138'(s_maddr), 138'(32'h8000_0200));
    tick("stall_c2");
    chk("stall_addr_c2", 138'(s_maddr), 138'(32'h8000_0200));
    set_in(1, 32'h8000_0200, 1, 32'h8000_3000, 0, 0, 0, 1, 0, 0);
    tick("stall_c3");
    chk("stall_accept", 138'({s_irr, s_lrr, s_maddr}), 138'({2'b10, 32'h8000_0200}));
    set_in(0, 0, 1, 32'h8000_3000, 0, 0, 0, 0, 1, 32'h5555_0000);
    tick("stall_c4");
    set_in(0, 0, 1, 32'h8000_3000, 0, 0, 0, 1, 0, 0);
    tick("stall_c5");
    chk("stall_lsu_later", 138'(s_lrr), 138'(1));
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h5555_0001);
    tick("stall_c6");

    // Partial store
    set_in(0, 0, 1, 32'h8000_1000, 1, 32'hDEAD_BEEF, 4'h3, 1, 0, 0);
    tick("store_c0");
    chk("store_wen_strb", 138'({s_mwen, s_mwstrb}), 138'({1'b1, 4'h3}));
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h1234_5678);
    tick("store_c1");
    chk("store_ack", 138'({s_lrv, s_lrd}), 138'({1'b1, 32'h0}));

    // Reset while a response is pending abandons the transaction
    set_in(1, 32'h8000_0400, 0, 0, 0, 0, 0, 1, 0, 0);
    tick("rst_c0");
    i_rst_n = 1'b0;
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    tick("rst_c1");
    i_rst_n = 1'b1;
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h7777_7777);
    tick("rst_c2");
    chk("rst_late_resp", 138'({s_irv, s_lrv}), 138'(0));
    set_in(1, 32'h8000_0500, 0, 0, 0, 0, 0, 1, 0, 0);
    tick("rst_c3");
    chk("rst_regrant", 138'(s_irr), 138'(1));
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h8888_8888);
    tick("rst_c4");

    // Randomized traffic, including stray responses and occasional resets
    for (int i = 0; i < 600; i++) begin
      i_rst_n = ($urandom_range(99) != 0);
      set_in(bit'($urandom_range(1)), $urandom, bit'($urandom_range(1)), $urandom,
             bit'($urandom_range(1)), $urandom, 4'($urandom),
             bit'($urandom_range(1)), ($urandom_range(9) < 4), $urandom);
      tick("random");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ysyx_23060124_mem_arbiter.md
YSYX_23060124_MEM_ARBITER -- requirements
Module: ysyx_23060124_mem_arbiter

Interface
REQ-001 SHALL have ports: clk  in  1  sole clock, all state on rising edge.
REQ-002 SHALL have: i_rst_n  in  1  reset, synchronous, active-low.
REQ-003 SHALL have: ifu_req_valid  in  1  instruction fetch request.
REQ-004 SHALL have: ifu_req_ready  out  1  fetch request accepted this cycle.
REQ-005 SHALL have: ifu_addr  in  32  fetch address (pc).
REQ-006 SHALL have: ifu_resp_valid  out  1  fetch data valid, one-cycle pulse.
REQ-007 SHALL have: ifu_rdata  out  32  fetched instruction.
REQ-008 SHALL have: lsu_req_valid  in  1  load/store request.
REQ-009 SHALL have: lsu_req_ready  out  1  load/store request accepted this cycle.
REQ-010 SHALL have: lsu_addr  in  32  load/store address.
REQ-011 SHALL have: lsu_wen  in  1  1 = store, 0 = load.
REQ-012 SHALL have: lsu_wdata  in  32  store data.
REQ-013 SHALL have: lsu_wstrb  in  4  store byte enables.
REQ-014 SHALL have: lsu_resp_valid  out  1  load data / store ack, one-cycle pulse.
REQ-015 SHALL have: lsu_rdata  out  32  load data.
REQ-016 SHALL have: mem_req_valid / mem_req_ready  out / in  1 each  shared memory request handshake.
REQ-017 SHALL have: mem_addr, mem_wdata  out  32 each; mem_wen  out  1; mem_wstrb  out  4  request payload.
REQ-018 SHALL have: mem_resp_valid  in  1; mem_rdata  in  32  memory response (always accepted).

Function
REQ-019 SHALL implement FSM IDLE, REQ, RESP with owner register (IFU/LSU); one outstanding transaction maximum.
REQ-020 IDLE: if any req_valid, SHALL pick winner combinationally, drive mem_req_valid=1 with winner payload same cycle.
REQ-021 IDLE, mem_req_ready=1: SHALL assert winner req_ready same cycle, latch owner, go RESP.
REQ-022 IDLE, mem_req_ready=0: SHALL latch owner and full payload, go REQ; payload and owner frozen even if other requester becomes valid or winner drops valid.
REQ-023 REQ: SHALL drive mem_req_valid=1 from latched payload; on mem_req_ready assert owner req_ready, go RESP.
REQ-024 RESP: mem_req_valid=0, both req_ready=0; on mem_resp_valid SHALL pulse owner resp_valid and pass mem_rdata same cycle (zero added latency), go IDLE.
REQ-025 Next grant SHALL be earliest the cycle after a response; back-to-back throughput = 1 transaction per (accept + memory latency + 1) cycles.
REQ-026 IFU grants SHALL drive mem_wen=0, mem_wstrb=0, mem_wdata=0.
REQ-027 mem_resp_valid outside RESP SHALL be ignored; non-owner resp_valid and all rdata outputs SHALL be 0 when not pulsing.
REQ-028 Default arbitration SHALL be fixed priority: LSU beats IFU on simultaneous valid.

Reset
REQ-029 With i_rst_n=0 at an edge: state=IDLE, owner=LSU, last-grant=LSU, latched payload=0; outstanding transaction abandoned, late response ignored.
REQ-030 While i_rst_n=0 all outputs SHALL be 0.

Configuration
REQ-031 Macro YSYX_23060124_ARB_RR_EN defined: round-robin; on simultaneous valid grant the requester not granted last; last-grant updates on each accept; first tie after reset goes to IFU.
REQ-032 Macro undefined: fixed priority per REQ-028; no last-grant register.

Structure
REQ-033 Shared header SHALL hold state encoding, owner encoding, 32-bit width constant (ysyx_23060124_ISA_WIDTH), strobe width 4.
REQ-034 Winner selection SHALL be sub-module ysyx_23060124_arb_pick (valids, last-grant in; one-hot grant out).

Verification
REQ-035 IFU only, addr 0x80000000, mem_req_ready=1, response 2 cycles later with 0x00100073 -> ifu_req_ready cycle 0, ifu_resp_valid + rdata 0x00100073 cycle 2, lsu outputs 0.
REQ-036 Both valid same cycle, no macro -> LSU granted first; IFU granted cycle after LSU response; with macro after reset -> IFU first, then LSU.
REQ-037 IFU valid, mem_req_ready=0 for 3 cycles, LSU valid from cycle 1 -> mem_addr stays IFU address, IFU accepted cycle 3, LSU waits.
REQ-038 LSU store addr 0x80001000, wdata 0xDEADBEEF, wstrb 0x3 -> mem_wen=1, mem_wstrb=0x3, lsu_resp_valid pulse on ack, lsu_rdata=0.
REQ-039 i_rst_n low for 1 cycle while in RESP, then mem_resp_valid -> no resp_valid pulse, state IDLE, next request granted normally.
